dcache_req_queue: RTL and testbench
===================================

DCACHE_REQ_QUEUE -- requirements
Module: dcache_req_queue

Interface
REQ-001 SHALL have parameter: QDEPTH, 2, request queue entries (power of two, 2..8).
REQ-002 SHALL have parameter: TIMEOUT_CYCLES, 255, watchdog limit in cycles (1..255, only with REQ-040).
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have upstream ports (from store buffer): req_i in 1; w_en_i in 1; addr_i in 32; wdata_i in 32; sel_byte_i in 4; dmem_sel_i in 1.
REQ-006 SHALL have upstream return ports: ack_o out 1; rdata_o out 32.
REQ-007 SHALL have dcache ports: dcache_req_o out 1; dcache_w_en_o out 1; dcache_addr_o out 32; dcache_wdata_o out 32; dcache_sel_byte_o out 4; dmem_sel_o out 1.
REQ-008 SHALL have dcache return ports: dcache_ack_i in 1; dcache_rdata_i in 32.
REQ-009 SHALL have status ports: empty_o out 1 (queue empty and nothing in flight); full_o out 1; timeout_o out 1.

Function
REQ-010 Queue SHALL be a QDEPTH-entry circular FIFO of {w_en, addr, wdata, sel_byte, dmem_sel}, log2(QDEPTH)+1-bit read/write pointers, wrap by pointer MSB.
REQ-011 Upstream request held stable with req_i=1 until ack_o=1; in the cycle ack_o=1, req_i SHALL be ignored (same transaction).
REQ-012 Store (req_i=1, w_en_i=1) SHALL push when not full; ack_o SHALL pulse exactly 1 cycle, registered, the cycle after push (posted write).
REQ-013 Store while full SHALL not push and not ack; retried each cycle until a slot frees.
REQ-014 Load (req_i=1, w_en_i=0) SHALL push only when empty_o=1 (drain-before-load ordering; no forwarding).
REQ-015 Load ack_o SHALL be asserted in the same cycle as the matching dcache_ack_i, with rdata_o=dcache_rdata_i; rdata_o SHALL be 0 otherwise.
REQ-016 Downstream FSM states: IDLE, REQ. IDLE->REQ when queue non-empty (next cycle); REQ->IDLE on dcache_ack_i when queue becomes empty; REQ->REQ on dcache_ack_i with further entries (back-to-back, next head presented next cycle).
REQ-017 In REQ, dcache_req_o=1 and dcache_* outputs SHALL equal head entry, stable until dcache_ack_i; head popped on dcache_ack_i.
REQ-018 dcache_ack_i in IDLE SHALL be ignored.
REQ-019 At most one dcache request outstanding.
REQ-020 Push and pop in the same cycle SHALL both take effect; full queue with simultaneous pop SHALL accept the push.
REQ-021 empty_o=1 iff count=0 and state=IDLE; full_o=1 iff count=QDEPTH.
REQ-022 Latency store-in to dcache_req_o: 2 cycles from req_i on empty idle queue.
REQ-023 In IDLE, dcache_req_o=0, dcache_w_en_o=0, other dcache_* outputs SHALL be 0.

Reset
REQ-030 rst=1 SHALL clear pointers, count, FSM to IDLE, ack_o=0, rdata_o=0, dcache_req_o=0, all dcache_* outputs 0, empty_o=1, full_o=0, timeout_o=0.
REQ-031 rst mid-transaction SHALL discard queued and in-flight entries; a dcache_ack_i in the cycle after reset SHALL be ignored.

Configuration
REQ-040 With DCACHE_REQ_TIMEOUT_EN defined: 8-bit counter clears on entering REQ or on dcache_ack_i, increments each REQ cycle; reaching TIMEOUT_CYCLES sets timeout_o sticky until rst; request stays asserted.
REQ-041 Without DCACHE_REQ_TIMEOUT_EN: no counter, timeout_o tied 0.

Verification
REQ-050 Reset, then store addr=0x8000_0010 wdata=0xDEAD_BEEF sel=0xF -> ack_o pulse cycle 1, dcache_req_o cycle 2 with same fields, empty_o=1 after dcache ack.
REQ-051 Three stores, dcache_ack_i held 0 (QDEPTH=2) -> two acks, third stalled, full_o=1; one dcache ack -> third acked next cycle, order preserved.
REQ-052 Store then load addr=0x8000_0020, dcache_rdata_i=0x1234_5678 -> load waits until store acked by dcache, then ack_o with rdata_o=0x1234_5678 same cycle as dcache_ack_i.
REQ-053 Simultaneous push and pop on full queue -> count stays 2, no entry lost, wrap-around order correct over 10 stores.
REQ-054 rst pulsed during REQ with 2 queued -> all outputs reset values next cycle, stray dcache_ack_i ignored.
REQ-055 DCACHE_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, no dcache ack -> timeout_o=1 after 16 REQ cycles, remains 1 after late ack; undefined macro -> timeout_o=0.

Source files
------------

// File: rtl/dcache_req_queue.sv
// Request queue between the store buffer and the dcache: posted stores, drain-before-load ordering.
// Optional watchdog on the outstanding dcache request is built when DCACHE_REQ_TIMEOUT_EN is defined.
module dcache_req_queue #(
  parameter int unsigned QDEPTH         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        w_en_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  sel_byte_i,
  input  logic        dmem_sel_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        dcache_req_o,
  output logic        dcache_w_en_o,
  output logic [31:0] dcache_addr_o,
  output logic [31:0] dcache_wdata_o,
  output logic [3:0]  dcache_sel_byte_o,
  output logic        dmem_sel_o,
  input  logic        dcache_ack_i,
  input  logic [31:0] dcache_rdata_i,
  output logic        empty_o,
  output logic        full_o,
  output logic        timeout_o
);

  localparam int unsigned AW = $clog2(QDEPTH);
  localparam int unsigned PW = AW + 1;

  if (QDEPTH < 2 || QDEPTH > 8 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_qdepth
    $error("QDEPTH must be a power of two in 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  typedef struct packed {
    logic        w_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel_byte;
    logic        dmem_sel;
  } entry_t;

  typedef enum logic {IDLE, REQ} state_t;

  entry_t        mem [QDEPTH];
  entry_t        in_entry;
  entry_t        head_next;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic [PW-1:0] count_next;
  state_t        state;
  state_t        state_next;
  logic          st_ack;
  logic          push;
  logic          pop;
  logic          load_ack;

  assign in_entry = '{w_en: w_en_i, addr: addr_i, wdata: wdata_i,
                      sel_byte: sel_byte_i, dmem_sel: dmem_sel_i};
  assign count    = wr_ptr - rd_ptr;

  // Handshakes: the ack cycle belongs to the same upstream transaction, so req_i is ignored then.
  assign pop      = (state == REQ) && dcache_ack_i;
  assign load_ack = pop && !dcache_w_en_o;
  assign ack_o    = st_ack | load_ack;
  assign rdata_o  = load_ack ? dcache_rdata_i : 32'h0;
  assign push     = req_i && !ack_o && (w_en_i ? (!full_o || pop) : empty_o);

  // Next state and the head entry to present on the dcache port next cycle.
  always_comb begin
    state_next = state;
    head_next  = mem[rd_ptr[AW-1:0]];
    count_next = count + PW'(push) - PW'(pop);
    case (state)
      IDLE: begin
        if (count != '0) state_next = REQ;
      end
      REQ: begin
        if (pop) begin
          if (count_next == '0) begin
            state_next = IDLE;
          end else if (count == PW'(1)) begin
            head_next = in_entry;
          end else begin
            head_next = mem[rd_ptr[AW-1:0] + AW'(1)];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      state             <= IDLE;
      st_ack            <= 1'b0;
      empty_o           <= 1'b1;
      full_o            <= 1'b0;
      dcache_req_o      <= 1'b0;
      dcache_w_en_o     <= 1'b0;
      dcache_addr_o     <= 32'h0;
      dcache_wdata_o    <= 32'h0;
      dcache_sel_byte_o <= 4'h0;
      dmem_sel_o        <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + PW'(push);
      rd_ptr  <= rd_ptr + PW'(pop);
      state   <= state_next;
      st_ack  <= push && w_en_i;
      empty_o <= (count_next == '0) && (state_next == IDLE);
      full_o  <= (count_next == PW'(QDEPTH));
      if (state_next == REQ) begin
        dcache_req_o      <= 1'b1;
        dcache_w_en_o     <= head_next.w_en;
        dcache_addr_o     <= head_next.addr;
        dcache_wdata_o    <= head_next.wdata;
        dcache_sel_byte_o <= head_next.sel_byte;
        dmem_sel_o        <= head_next.dmem_sel;
      end else begin
        dcache_req_o      <= 1'b0;
        dcache_w_en_o     <= 1'b0;
        dcache_addr_o     <= 32'h0;
        dcache_wdata_o    <= 32'h0;
        dcache_sel_byte_o <= 4'h0;
        dmem_sel_o        <= 1'b0;
      end
    end
  end

`ifdef DCACHE_REQ_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Watchdog counts cycles a request waits; the flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt   <= 8'h0;
      timeout_o <= 1'b0;
    end else begin
      if (state != REQ || dcache_ack_i) begin
        tmo_cnt <= 8'h0;
      end else if (tmo_cnt != 8'hFF) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (state == REQ && !dcache_ack_i && (9'(tmo_cnt) + 9'd1 == 9'(TIMEOUT_CYCLES))) begin
        timeout_o <= 1'b1;
      end
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_req_queue.sv
// Directed bench for dcache_req_queue: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_dcache_req_queue;

  typedef struct packed {
    logic        w_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        dmem;
  } tx_t;

  typedef struct packed {
    logic        ack;
    logic [31:0] rdata;
    logic        dreq;
    tx_t         head;
    logic        empty;
    logic        full;
    logic        tmo;
  } obs_t;

  typedef struct {
    string       name;
    logic        req;
    tx_t         t;
    logic        dack;
    logic [31:0] drdata;
    obs_t        e;
  } vec_t;

`ifdef DCACHE_REQ_TIMEOUT_EN
  localparam logic TMO_EXP = 1'b1;
`else
  localparam logic TMO_EXP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req;
  logic        w_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel_byte;
  logic        dmem_sel;
  logic        ack;
  logic [31:0] rdata;
  logic        dcache_req;
  logic        dcache_w_en;
  logic [31:0] dcache_addr;
  logic [31:0] dcache_wdata;
  logic [3:0]  dcache_sel_byte;
  logic        dmem_sel_out;
  logic        dcache_ack;
  logic [31:0] dcache_rdata;
  logic        empty;
  logic        full;
  logic        timeout;

  int n_vec = 0;
  int n_bad = 0;

  dcache_req_queue #(.QDEPTH(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_i(req), .w_en_i(w_en), .addr_i(addr), .wdata_i(wdata),
    .sel_byte_i(sel_byte), .dmem_sel_i(dmem_sel),
    .ack_o(ack), .rdata_o(rdata),
    .dcache_req_o(dcache_req), .dcache_w_en_o(dcache_w_en), .dcache_addr_o(dcache_addr),
    .dcache_wdata_o(dcache_wdata), .dcache_sel_byte_o(dcache_sel_byte), .dmem_sel_o(dmem_sel_out),
    .dcache_ack_i(dcache_ack), .dcache_rdata_i(dcache_rdata),
    .empty_o(empty), .full_o(full), .timeout_o(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam tx_t NONE = '0;
  localparam tx_t SA   = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1};
  localparam tx_t S1   = '{1'b1, 32'h0000_0100, 32'h1111_1111, 4'hF, 1'b0};
  localparam tx_t S2   = '{1'b1, 32'h0000_0104, 32'h2222_2222, 4'h3, 1'b1};
  localparam tx_t S3   = '{1'b1, 32'h0000_0108, 32'h3333_3333, 4'hC, 1'b0};
  localparam tx_t SC   = '{1'b1, 32'h0000_0200, 32'h0000_00AA, 4'h1, 1'b0};
  localparam tx_t LC   = '{1'b0, 32'h8000_0020, 32'h0000_0000, 4'hF, 1'b1};
  localparam obs_t IDLE_EMPTY = '{1'b0, 32'h0, 1'b0, NONE, 1'b1, 1'b0, 1'b0};

  function automatic vec_t mkv(string n, logic rq, tx_t t, logic dk, logic [31:0] rd,
                               logic ea, logic [31:0] erd, logic edq, tx_t h,
                               logic ee, logic ef);
    vec_t v;
    v.name = n; v.req = rq; v.t = t; v.dack = dk; v.drdata = rd;
    v.e = '{ea, erd, edq, h, ee, ef, 1'b0};
    return v;
  endfunction

  task automatic drive(logic rq, tx_t t, logic dk, logic [31:0] rd);
    req = rq; w_en = t.w_en; addr = t.addr; wdata = t.wdata;
    sel_byte = t.sel; dmem_sel = t.dmem; dcache_ack = dk; dcache_rdata = rd;
  endtask

  task automatic check(string n, obs_t e);
    obs_t a;
    a = {ack, rdata, dcache_req,
         {dcache_w_en, dcache_addr, dcache_wdata, dcache_sel_byte, dmem_sel_out},
         empty, full, timeout};
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic cmp_val(string n, logic [127:0] a, logic [127:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Hold a store until its ack, with a bounded wait.
  task automatic do_store(tx_t t);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      drive(1'b1, t, 1'b0, 32'h0);
      @(negedge clk);
      if (ack) got = 1;
    end
    if (!got) begin
      n_vec++; n_bad++;
      $display("FAIL store_ack_wait: got no ack expected ack within 20 cycles");
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive(1'b0, NONE, 1'b0, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  vec_t vq[$];
  tx_t  st[10];

  initial begin
    rst = 1'b1;
    drive(1'b0, NONE, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset", IDLE_EMPTY);

    // Single posted store, then stray dcache ack while idle
    vq.push_back(mkv("a0", 1, SA,   0, 0, 0, 0, 0, NONE, 1, 0));
    vq.push_back(mkv("a1", 1, SA,   0, 0, 1, 0, 0, NONE, 0, 0));
    vq.push_back(mkv("a2", 0, NONE, 0, 0, 0, 0, 1, SA,   0, 0));
    vq.push_back(mkv("a3", 0, NONE, 1, 0, 0, 0, 1, SA,   0, 0));
    vq.push_back(mkv("a4", 0, NONE, 0, 0, 0, 0, 0, NONE, 1, 0));
    vq.push_back(mkv("a5", 0, NONE, 1, 0, 0, 0, 0, NONE, 1, 0));
    // Three stores against a stalled dcache, then drain
    vq.push_back(mkv("b0", 1, S1,   0, 0, 0, 0, 0, NONE, 1, 0));
    vq.push_back(mkv("b1", 1, S1,   0, 0, 1, 0, 0, NONE, 0, 0));
    vq.push_back(mkv("b2", 1, S2,   0, 0, 0, 0, 1, S1,   0, 0));
    vq.push_back(mkv("b3", 1, S2,   0, 0, 1, 0, 1, S1,   0, 1));
    vq.push_back(mkv("b4", 1, S3,   0, 0, 0, 0, 1, S1,   0, 1));
    vq.push_back(mkv("b5", 1, S3,   0, 0, 0, 0, 1, S1,   0, 1));
    vq.push_back(mkv("b6", 1, S3,   1, 0, 0, 0, 1, S1,   0, 1));
    vq.push_back(mkv("b7", 1, S3,   0, 0, 1, 0, 1, S2,   0, 1));
    vq.push_back(mkv("b8", 0, NONE, 1, 0, 0, 0, 1, S2,   0, 1));
    vq.push_back(mkv("b9", 0, NONE, 1, 0, 0, 0, 1, S3,   0, 0));
    vq.push_back(mkv("b10", 0, NONE, 0, 0, 0, 0, 0, NONE, 1, 0));
    // Store then load: load waits for drain, ack with read data on the dcache ack cycle
    vq.push_back(mkv("c0", 1, SC, 0, 0, 0, 0, 0, NONE, 1, 0));
    vq.push_back(mkv("c1", 1, SC, 0, 0, 1, 0, 0, NONE, 0, 0));
    vq.push_back(mkv("c2", 1, LC, 0, 0, 0, 0, 1, SC,   0, 0));
    vq.push_back(mkv("c3", 1, LC, 1, 32'hCAFE_F00D, 0, 0, 1, SC, 0, 0));
    vq.push_back(mkv("c4", 1, LC, 0, 0, 0, 0, 0, NONE, 1, 0));
    vq.push_back(mkv("c5", 1, LC, 0, 0, 0, 0, 0, NONE, 0, 0));
    vq.push_back(mkv("c6", 1, LC, 0, 0, 0, 0, 1, LC,   0, 0));
    vq.push_back(mkv("c7", 1, LC, 1, 32'h1234_5678, 1, 32'h1234_5678, 1, LC, 0, 0));
    vq.push_back(mkv("c8", 0, NONE, 0, 32'h1234_5678, 0, 0, 0, NONE, 1, 0));

    foreach (vq[i]) begin
      @(posedge clk); #1;
      drive(vq[i].req, vq[i].t, vq[i].dack, vq[i].drdata);
      @(negedge clk);
      check(vq[i].name, vq[i].e);
    end

    // Ten stores through the 2-entry queue with push and pop together on a full queue
    for (int i = 0; i < 10; i++) begin
      st[i] = '{1'b1, 32'h0000_1000 + 32'(4 * i), 32'hA5A5_0000 + 32'(i), 4'(i), 1'(i)};
    end
    begin
      int  sent = 0;
      int  rcv  = 0;
      bit  filled = 0;
      logic dk = 1'b0;
      for (int cyc = 0; cyc < 400 && rcv < 10; cyc++) begin
        @(posedge clk); #1;
        dk = filled ? ~dk : 1'b0;
        if (sent < 10) drive(1'b1, st[sent], dk, 32'h0);
        else drive(1'b0, NONE, dk, 32'h0);
        @(negedge clk);
        if (full) filled = 1;
        if (ack && req) sent++;
        if (dcache_req && dcache_ack) begin
          cmp_val($sformatf("wrap_%0d", rcv),
                  128'({dcache_w_en, dcache_addr, dcache_wdata, dcache_sel_byte, dmem_sel_out}),
                  128'(st[rcv]));
          rcv++;
        end
      end
      if (rcv != 10) begin
        n_vec++; n_bad++;
        $display("FAIL wrap_count: got %0d dcache handshakes expected 10", rcv);
      end
      @(posedge clk); #1;
      drive(1'b0, NONE, 1'b0, 32'h0);
      @(negedge clk);
      check("wrap_drained", IDLE_EMPTY);
    end

    // Reset while a request is in flight with two entries queued
    do_store(S1);
    do_store(S2);
    @(posedge clk); #1;
    drive(1'b0, NONE, 1'b0, 32'h0);
    @(negedge clk);
    check("pre_rst_full", '{1'b0, 32'h0, 1'b1, S1, 1'b0, 1'b1, 1'b0});
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dcache_ack = 1'b1;
    @(negedge clk);
    check("rst_mid", IDLE_EMPTY);
    @(posedge clk); #1;
    dcache_ack = 1'b0;
    @(negedge clk);
    check("rst_stray_ack", IDLE_EMPTY);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_stays_idle", IDLE_EMPTY);

    // Watchdog: stalled dcache for 20 request cycles, then a late ack
    do_store(S3);
    begin
      int reqcyc = 0;
      for (int i = 0; i < 30 && reqcyc < 20; i++) begin
        @(posedge clk); #1;
        drive(1'b0, NONE, 1'b0, 32'h0);
        @(negedge clk);
        if (dcache_req) reqcyc++;
        if (reqcyc == 16) check("tmo_at_16", '{1'b0, 32'h0, 1'b1, S3, 1'b0, 1'b0, 1'b0});
        if (reqcyc == 17) check("tmo_at_17", '{1'b0, 32'h0, 1'b1, S3, 1'b0, 1'b0, TMO_EXP});
      end
      if (reqcyc != 20) begin
        n_vec++; n_bad++;
        $display("FAIL tmo_req_cycles: got %0d expected 20", reqcyc);
      end
    end
    @(posedge clk); #1;
    dcache_ack = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    dcache_ack = 1'b0;
    @(negedge clk);
    check("tmo_sticky", '{1'b0, 32'h0, 1'b0, NONE, 1'b1, 1'b0, TMO_EXP});
    do_reset();
    check("tmo_cleared", IDLE_EMPTY);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
